// File: rtl/serial_mag_comparator.sv
// Serial unsigned magnitude comparator.
// Resolves A vs B MSB-first, one 2-bit chunk per clock.
module serial_mag_comparator #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             A_gt_b,
   output logic             A_eq_b,
   output logic             A_lt_b
);

   localparam int NCHUNK = WIDTH / 2;
   localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

   generate
      if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
         $error("WIDTH must be even and >= 2");
      end
   endgenerate

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t           r_state;
   state_t           w_state_nx;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] w_a_nx;
   logic [WIDTH-1:0] w_b_nx;
   logic [IW-1:0]    r_idx;
   logic [IW-1:0]    w_idx_nx;
   logic             r_done;
   logic             w_done_nx;
   logic             r_gt;
   logic             r_eq;
   logic             r_lt;
   logic             w_gt_nx;
   logic             w_eq_nx;
   logic             w_lt_nx;

   // Operands shift left each step, so the live chunk is always the top pair.
   logic [1:0] w_ca;
   logic [1:0] w_cb;
   logic       w_chunk_gt;
   logic       w_chunk_lt;

   assign w_ca       = r_a[WIDTH-1 -: 2];
   assign w_cb       = r_b[WIDTH-1 -: 2];
   assign w_chunk_gt = (w_ca > w_cb);
   assign w_chunk_lt = (w_ca < w_cb);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_idx   <= '0;
         r_done  <= 1'b0;
         r_gt    <= 1'b0;
         r_eq    <= 1'b0;
         r_lt    <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_a     <= w_a_nx;
         r_b     <= w_b_nx;
         r_idx   <= w_idx_nx;
         r_done  <= w_done_nx;
         r_gt    <= w_gt_nx;
         r_eq    <= w_eq_nx;
         r_lt    <= w_lt_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_a_nx     = r_a;
      w_b_nx     = r_b;
      w_idx_nx   = r_idx;
      w_done_nx  = 1'b0;
      w_gt_nx    = r_gt;
      w_eq_nx    = r_eq;
      w_lt_nx    = r_lt;
      unique case (r_state)
         IDLE: begin
            if (start) begin
               w_state_nx = RUN;
               w_a_nx     = A;
               w_b_nx     = B;
               w_idx_nx   = '0;
               w_gt_nx    = 1'b0;
               w_eq_nx    = 1'b0;
               w_lt_nx    = 1'b0;
            end
         end
         RUN: begin
            unique case (1'b1)
               w_chunk_gt: begin
                  w_gt_nx    = 1'b1;
                  w_done_nx  = 1'b1;
                  w_state_nx = IDLE;
               end
               w_chunk_lt: begin
                  w_lt_nx    = 1'b1;
                  w_done_nx  = 1'b1;
                  w_state_nx = IDLE;
               end
               default: begin
                  if (r_idx == LAST) begin
                     w_eq_nx    = 1'b1;
                     w_done_nx  = 1'b1;
                     w_state_nx = IDLE;
                  end else begin
                     w_idx_nx = r_idx + 1'b1;
                     w_a_nx   = r_a << 2;
                     w_b_nx   = r_b << 2;
                  end
               end
            endcase
         end
         default: w_state_nx = IDLE;
      endcase
   end

   assign busy   = (r_state == RUN);
   assign done   = r_done;
   assign A_gt_b = r_gt;
   assign A_eq_b = r_eq;
   assign A_lt_b = r_lt;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed testbench for serial_mag_comparator, WIDTH=8.
// Inputs change 1ns after rising edges; outputs sampled there too.
module tb_serial_mag_comparator;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] A;
   logic [7:0] B;
   logic       busy;
   logic       done;
   logic       A_gt_b;
   logic       A_eq_b;
   logic       A_lt_b;

   int total;
   int bad;

   serial_mag_comparator #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .A      (A),
      .B      (B),
      .busy   (busy),
      .done   (done),
      .A_gt_b (A_gt_b),
      .A_eq_b (A_eq_b),
      .A_lt_b (A_lt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launches one compare; returns latency, busy-high count, flags seen while busy.
   task automatic run_cmp(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int bcnt,
                          output logic fbusy);
      A = a;
      B = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      bcnt = 0;
      fbusy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (busy) begin
            bcnt++;
            if (A_gt_b || A_eq_b || A_lt_b) fbusy = 1'b1;
         end
         tick();
         lat++;
         if (done) break;
      end
      if (!done) lat = 99;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b1;
      A = 8'hC0;
      B = 8'h40;
      #3;
      total++;
      if ({busy, done, A_gt_b, A_eq_b, A_lt_b} !== 5'b0) begin
         $display("FAIL reset_outs got=%b want=00000",
                  {busy, done, A_gt_b, A_eq_b, A_lt_b});
         bad++;
      end
      tick();
      tick();
      total++;
      if (busy !== 1'b0) begin
         $display("FAIL reset_start_ignored busy got=%b want=0", busy);
         bad++;
      end
      start = 1'b0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_gt();
      int lat, bcnt;
      logic fb;
      run_cmp(8'hC0, 8'h40, lat, bcnt, fb);
      total++;
      if (lat !== 1) begin
         $display("FAIL gt_latency got=%0d want=1", lat);
         bad++;
      end
      total++;
      if ({busy, A_gt_b, A_eq_b, A_lt_b} !== 4'b0100) begin
         $display("FAIL gt_flags got=%b want=0100",
                  {busy, A_gt_b, A_eq_b, A_lt_b});
         bad++;
      end
      total++;
      if (fb !== 1'b0) begin
         $display("FAIL gt_flags_busy got=%b want=0", fb);
         bad++;
      end
      tick();
      total++;
      if ({done, A_gt_b, A_eq_b, A_lt_b} !== 4'b0100) begin
         $display("FAIL gt_hold got=%b want=0100",
                  {done, A_gt_b, A_eq_b, A_lt_b});
         bad++;
      end
   endtask

   task automatic test_lt();
      int lat, bcnt;
      logic fb;
      run_cmp(8'h5A, 8'h5B, lat, bcnt, fb);
      total++;
      if (lat !== 4) begin
         $display("FAIL lt_latency got=%0d want=4", lat);
         bad++;
      end
      total++;
      if (bcnt !== 4) begin
         $display("FAIL lt_busy_cycles got=%0d want=4", bcnt);
         bad++;
      end
      total++;
      if ({busy, A_gt_b, A_eq_b, A_lt_b} !== 4'b0001) begin
         $display("FAIL lt_flags got=%b want=0001",
                  {busy, A_gt_b, A_eq_b, A_lt_b});
         bad++;
      end
      total++;
      if (fb !== 1'b0) begin
         $display("FAIL lt_flags_busy got=%b want=0", fb);
         bad++;
      end
      tick();
   endtask

   task automatic test_eq();
      int lat, bcnt;
      logic fb;
      run_cmp(8'hFF, 8'hFF, lat, bcnt, fb);
      total++;
      if (lat !== 4 || {A_gt_b, A_eq_b, A_lt_b} !== 3'b010) begin
         $display("FAIL eq_ff got lat=%0d flags=%b want lat=4 flags=010",
                  lat, {A_gt_b, A_eq_b, A_lt_b});
         bad++;
      end
      tick();
      run_cmp(8'h00, 8'h00, lat, bcnt, fb);
      total++;
      if (lat !== 4 || {A_gt_b, A_eq_b, A_lt_b} !== 3'b010) begin
         $display("FAIL eq_00 got lat=%0d flags=%b want lat=4 flags=010",
                  lat, {A_gt_b, A_eq_b, A_lt_b});
         bad++;
      end
      tick();
   endtask

   task automatic test_busy_ignore();
      int lat;
      A = 8'h12;
      B = 8'h13;
      start = 1'b1;
      tick();
      start = 1'b0;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         A = (i % 2 == 0) ? 8'hFF : 8'h00;
         B = (i % 2 == 0) ? 8'h00 : 8'hFF;
         start = (i < 2) ? 1'b1 : 1'b0;
         tick();
         lat++;
         if (done) break;
      end
      start = 1'b0;
      if (!done) lat = 99;
      total++;
      if (lat !== 4 || {A_gt_b, A_eq_b, A_lt_b} !== 3'b001) begin
         $display("FAIL busy_ignore got lat=%0d flags=%b want lat=4 flags=001",
                  lat, {A_gt_b, A_eq_b, A_lt_b});
         bad++;
      end
      tick();
      total++;
      if (busy !== 1'b0) begin
         $display("FAIL busy_not_queued busy got=%b want=0", busy);
         bad++;
      end
   endtask

   task automatic test_back_to_back();
      int n;
      start = 1'b1;
      A = 8'hC0;
      B = 8'h40;
      tick();
      tick();
      total++;
      if ({done, A_gt_b, A_eq_b, A_lt_b} !== 4'b1100) begin
         $display("FAIL b2b_first got=%b want=1100",
                  {done, A_gt_b, A_eq_b, A_lt_b});
         bad++;
      end
      A = 8'h40;
      B = 8'hC0;
      tick();
      total++;
      if ({busy, done, A_gt_b, A_eq_b, A_lt_b} !== 5'b10000) begin
         $display("FAIL b2b_accept got=%b want=10000",
                  {busy, done, A_gt_b, A_eq_b, A_lt_b});
         bad++;
      end
      tick();
      total++;
      if ({done, A_gt_b, A_eq_b, A_lt_b} !== 4'b1001) begin
         $display("FAIL b2b_second got=%b want=1001",
                  {done, A_gt_b, A_eq_b, A_lt_b});
         bad++;
      end
      A = 8'h77;
      B = 8'h77;
      tick();
      n = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         n++;
         if (done) break;
      end
      start = 1'b0;
      total++;
      if (n !== 4 || {done, A_gt_b, A_eq_b, A_lt_b} !== 4'b1010) begin
         $display("FAIL b2b_third got lat=%0d out=%b want lat=4 out=1010",
                  n, {done, A_gt_b, A_eq_b, A_lt_b});
         bad++;
      end
      tick();
      total++;
      if ({busy, done, A_eq_b} !== 3'b001) begin
         $display("FAIL b2b_idle got=%b want=001", {busy, done, A_eq_b});
         bad++;
      end
   endtask

   task automatic test_reset_mid();
      int lat, bcnt;
      logic fb;
      logic seen;
      A = 8'h33;
      B = 8'h33;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, done, A_gt_b, A_eq_b, A_lt_b} !== 5'b0) begin
         $display("FAIL reset_mid_async got=%b want=00000",
                  {busy, done, A_gt_b, A_eq_b, A_lt_b});
         bad++;
      end
      start = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (done || busy) seen = 1'b1;
      end
      start = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (done || busy) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         $display("FAIL reset_mid_no_done got=%b want=0", seen);
         bad++;
      end
      run_cmp(8'h12, 8'h34, lat, bcnt, fb);
      total++;
      if (lat !== 2 || {A_gt_b, A_eq_b, A_lt_b} !== 3'b001) begin
         $display("FAIL reset_mid_after got lat=%0d flags=%b want lat=2 flags=001",
                  lat, {A_gt_b, A_eq_b, A_lt_b});
         bad++;
      end
      tick();
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst_n = 1'b0;
      start = 1'b0;
      A = 8'h00;
      B = 8'h00;
      test_reset();
      test_gt();
      test_lt();
      test_eq();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule

// File: doc/serial_mag_comparator.md
SERIAL_MAG_COMPARATOR -- requirements
Module: serial_mag_comparator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, the operand width in bits; it SHALL be even and at least 2.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset, as the first two ports listed below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin a compare; sampled on the clk rising edge.
REQ-006 A  input  WIDTH  first operand, unsigned; sampled only when start is accepted.
REQ-007 B  input  WIDTH  second operand, unsigned; sampled only when start is accepted.
REQ-008 busy  output  1  high while a compare is in progress.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 A_gt_b  output  1  registered result: A > B.
REQ-011 A_eq_b  output  1  registered result: A == B.
REQ-012 A_lt_b  output  1  registered result: A < B.

Function
REQ-013 The comparison SHALL treat both operands as unsigned and process them MSB-first, 2 bits (one chunk) per cycle, using WIDTH/2 chunks in total.
REQ-014 The FSM SHALL have two states: IDLE (busy=0) and RUN (busy=1).
REQ-015 In IDLE, when start=1 is sampled, the block SHALL latch A and B, set the chunk index to 0 (the MSB chunk), clear all three result flags to 0, and move to RUN.
REQ-016 In RUN, each clock edge SHALL compare the current chunk of A against the same chunk of B, with this outcome:
  - A chunk > B chunk: set A_gt_b=1, pulse done, return to IDLE.
  - A chunk < B chunk: set A_lt_b=1, pulse done, return to IDLE.
  - Chunks equal, not the last chunk: advance the index and stay in RUN.
  - Chunks equal, last chunk: set A_eq_b=1, pulse done, return to IDLE.
REQ-017 Latency, counted from the edge that accepts start to the edge that asserts done, SHALL be k cycles, where k is the 1-based index of the first differing chunk; when A==B, latency SHALL be WIDTH/2.
REQ-018 done SHALL be high for exactly one cycle, and busy SHALL fall on the same edge on which done rises.
REQ-019 After done, the result flags SHALL hold until the next start is accepted or reset is asserted.
REQ-020 Exactly one result flag SHALL be high from done onward, and all three flags SHALL be 0 while busy=1.
REQ-021 A start asserted while busy=1 SHALL be ignored; it SHALL NOT be queued and SHALL NOT alter the latched operands.
REQ-022 A start sampled in the cycle where done=1 (FSM in IDLE) SHALL be accepted: flags clear and a new compare begins.
REQ-023 Changes on A or B after start is accepted SHALL NOT affect the result in progress.

Reset
REQ-024 While rst_n=0, the block SHALL force state=IDLE, busy=0, done=0, A_gt_b=0, A_eq_b=0, A_lt_b=0, and clear the chunk index and operand registers, immediately and independent of clk.
REQ-025 Reset asserted mid-compare SHALL abort the compare with no done pulse; start SHALL be ignored while rst_n=0.
REQ-026 After rst_n rises, the first start sampled SHALL be accepted normally.

Verification (WIDTH=8)
REQ-027 Reset, then start with A=8'hC0, B=8'h40: the MSB chunk differs (11 vs 01), so A_gt_b=1 and done pulses 1 cycle after acceptance.
REQ-028 Start with A=8'h5A, B=8'h5B: A_lt_b=1 and done pulses at 4 cycles (last chunk 10 vs 11), with busy high for exactly 4 cycles.
REQ-029 Start with A=B=8'hFF, then A=B=8'h00: A_eq_b=1 at 4 cycles in each case.
REQ-030 Start with A=8'h12, B=8'h13, then toggle A/B and pulse start while busy=1: those inputs are ignored and the result is A_lt_b=1 at 4 cycles.
REQ-031 Hold start high continuously with alternating operands: back-to-back compares occur, each new start is accepted in the done cycle, and flags clear on acceptance.
REQ-032 Assert rst_n=0 in cycle 2 of an A=B compare: all outputs go to 0 asynchronously, no done pulse occurs, and a subsequent compare completes correctly.
